// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button conditioning, tick prescaler and increment/clear/hold generation.
// Optional STOPWATCH_DEBOUNCE_EN inserts a per-button debouncer between the synchroniser and the edge detector.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 500000,
  parameter int WRAP       = 0,
  parameter int DEB_CYCLES = 65536
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       at_max,
  output logic       inc,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state,
  output logic       run_led
);

  localparam int            PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  if (TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_param_check
    $error("stopwatch_ctrl: TICK_DIV must be >= 2 and DEB_CYCLES >= 1");
  end

  // Bit order everywhere below: {clear, start, lap}.
  logic [2:0] btn_raw, sync1, sync2, btn_lvl, btn_hist, press;
  assign btn_raw = {btn_clear, btn_start, btn_lap};

  // Flops reset high so a button held through reset release is not seen as a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= '1;
      sync2    <= '1;
      btn_hist <= '1;
      press    <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      btn_hist <= btn_lvl;
      press    <= btn_lvl & ~btn_hist;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] deb_cnt [3];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_lvl <= '1;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == btn_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          btn_lvl[i] <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end
`else
  assign btn_lvl = sync2;
`endif

  logic press_clear, press_start, press_lap;
  assign press_clear = press[2];
  assign press_start = press[1];
  assign press_lap   = press[0];

  state_t        cur, nxt;
  logic [PW-1:0] presc;
  logic          counting, tick, saturate, clr_nxt, presc_zero;

  // RUN and LAP are exactly the states with bit 0 set.
  assign counting = cur[0];
  assign tick     = counting && (presc == P_LAST);
  assign saturate = tick && at_max && (WRAP == 0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur   <= S_IDLE;
      hold  <= 1'b0;
      clr   <= 1'b0;
      presc <= '0;
    end else begin
      cur  <= nxt;
      hold <= (nxt == S_LAP);
      clr  <= clr_nxt;
      if (presc_zero)
        presc <= '0;
      else if (counting)
        presc <= tick ? '0 : presc + PW'(1);
    end
  end

  always_comb begin
    nxt        = cur;
    clr_nxt    = 1'b0;
    presc_zero = 1'b0;
    case (cur)
      S_IDLE: begin
        if (press_clear) begin
          clr_nxt    = 1'b1;
          presc_zero = 1'b1;
        end else if (press_start) begin
          nxt        = S_RUN;
          presc_zero = 1'b1;
        end
      end
      S_RUN: begin
        if (press_start)    nxt = S_PAUSE;
        else if (press_lap) nxt = S_LAP;
      end
      S_LAP: begin
        if (press_start)    nxt = S_PAUSE;
        else if (press_lap) nxt = S_RUN;
      end
      S_PAUSE: begin
        if (press_clear) begin
          nxt        = S_IDLE;
          clr_nxt    = 1'b1;
          presc_zero = 1'b1;
        end else if (press_start) begin
          nxt = S_RUN;
        end
      end
      default: nxt = S_IDLE;
    endcase
    // Reaching 5999 without rollover auto-pauses, overriding any button action.
    if (saturate) nxt = S_PAUSE;
  end

  always_comb begin
    inc     = tick && !(at_max && (WRAP == 0));
    run_led = cur[0];
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4: one saturating instance and one rollover instance.
module tb_stopwatch_ctrl;

  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11;

  logic clock = 1'b0;
  logic reset;
  logic btn_start, btn_lap, btn_clear, at_max;
  logic b1_start, b1_lap, b1_clear, at_max1;
  logic inc0, clr0, hold0, led0, inc1, clr1, hold1, led1;
  logic [1:0] st0, st1;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .WRAP(0), .DEB_CYCLES(8)) dut0 (
    .clock(clock), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .at_max(at_max), .inc(inc0), .clr(clr0),
    .hold(hold0), .state(st0), .run_led(led0)
  );

  stopwatch_ctrl #(.TICK_DIV(4), .WRAP(1), .DEB_CYCLES(8)) dut1 (
    .clock(clock), .reset(reset), .btn_start(b1_start), .btn_lap(b1_lap),
    .btn_clear(b1_clear), .at_max(at_max1), .inc(inc1), .clr(clr1),
    .hold(hold1), .state(st1), .run_led(led1)
  );

  typedef struct {
    int         cyc;
    logic       inc;
    logic       clr;
    logic       hold;
    logic [1:0] st;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  function automatic ev_t mk(int t, logic i, logic c, logic [1:0] s, logic h);
    ev_t e;
    e.cyc = t; e.inc = i; e.clr = c; e.st = s; e.hold = h;
    return e;
  endfunction

  task automatic cmp_ev(input string tag, input ev_t e, input int t, input logic i,
                        input logic c, input logic [1:0] s, input logic h, input logic led);
    logic led_exp;
    led_exp = (e.st == RUN) || (e.st == LAP);
    n_tests++;
    if (e.cyc != t || i !== e.inc || c !== e.clr || s !== e.st || h !== e.hold || led !== led_exp) begin
      n_fail++;
      $display("FAIL %s event: got cyc=%0d inc=%b clr=%b state=%b hold=%b led=%b, expected cyc=%0d inc=%b clr=%b state=%b hold=%b led=%b",
               tag, t, i, c, s, h, led, e.cyc, e.inc, e.clr, e.st, e.hold, led_exp);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: any cycle with inc, clr or a state change is an observable event.
  logic [1:0] prev0 = 2'b00;
  logic [1:0] prev1 = 2'b00;

  always @(posedge clock) begin
    #1;
    if (inc0 || clr0 || st0 != prev0) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut0 unexpected event: cyc=%0d inc=%b clr=%b state=%b", cyc, inc0, clr0, st0);
      end else begin
        cmp_ev("dut0", q0.pop_front(), cyc, inc0, clr0, st0, hold0, led0);
      end
    end
    prev0 = st0;
  end

  always @(posedge clock) begin
    #1;
    if (inc1 || clr1 || st1 != prev1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut1 unexpected event: cyc=%0d inc=%b clr=%b state=%b", cyc, inc1, clr1, st1);
      end else begin
        cmp_ev("dut1", q1.pop_front(), cyc, inc1, clr1, st1, hold1, led1);
      end
    end
    prev1 = st1;
  end

  task automatic wait_to(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 100000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != t) begin
      n_tests++; n_fail++;
      $display("FAIL wait_to: at cycle %0d, wanted %0d", cyc, t);
    end
  endtask

  // One-cycle clean pulse on the dut0 button pins.
  task automatic press(input logic s, input logic l, input logic c);
    btn_start = s; btn_lap = l; btn_clear = c;
    @(negedge clock);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
  endtask

  // Directed (cycle, inc, clr, state, hold) events, relative to the stimulus base.
  localparam int NEV = 18;
  int         ev_t_rel [NEV] = '{4, 7, 11, 12, 15, 19, 20, 22, 46, 47, 51, 55, 57, 64, 72, 75, 77, 80};
  logic       ev_inc   [NEV] = '{0, 1, 1,  0,  1,  1,  0,  0,  0,  1,  1,  1,  0,  0,  0,  1,  0,  0};
  logic       ev_clr   [NEV] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  0};
  logic [1:0] ev_st    [NEV] = '{RUN, RUN, RUN, LAP, LAP, LAP, RUN, PAUSE, RUN, RUN, RUN, RUN,
                                 PAUSE, IDLE, RUN, RUN, LAP, PAUSE};
  logic       ev_hold  [NEV] = '{0, 0, 0,  1,  1,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0};

  initial begin
    int b, c;
    reset = 1'b1;
    btn_start = 1'b1; btn_lap = 1'b0; btn_clear = 1'b0; at_max = 1'b0;
    b1_start = 1'b0; b1_lap = 1'b0; b1_clear = 1'b0; at_max1 = 1'b0;
    #1 reset = 1'b0;

    wait_to(2);
    check("rst_state", st0, IDLE);
    check("rst_inc", inc0, 0);
    check("rst_clr", clr0, 0);
    check("rst_hold", hold0, 0);
    check("rst_run_led", led0, 0);

    // btn_start held across reset release must not register as a press.
    wait_to(3);
    reset = 1'b1;
    wait_to(8);
    btn_start = 1'b0;
    wait_to(12);
    check("held_start_idle", st0, IDLE);

    b = 20;
    for (int i = 0; i < NEV; i++)
      q0.push_back(mk(b + ev_t_rel[i], ev_inc[i], ev_clr[i], ev_st[i], ev_hold[i]));

    wait_to(b);      press(1, 0, 0);   // IDLE -> RUN
    wait_to(b + 8);  press(0, 1, 0);   // RUN -> LAP
    wait_to(b + 16); press(0, 1, 0);   // LAP -> RUN
    wait_to(b + 18); press(1, 0, 0);   // RUN -> PAUSE with prescaler at 1, retained as 2
    wait_to(b + 42); press(1, 0, 0);   // resume: inc one cycle after RUN
    wait_to(b + 48); press(0, 0, 1);   // clear ignored in RUN
    wait_to(b + 53); press(1, 0, 0);   // RUN -> PAUSE
    wait_to(b + 60); press(1, 0, 1);   // start+clear in PAUSE: clear wins
    wait_to(b + 68); press(1, 0, 0);   // IDLE -> RUN from a zeroed prescaler
    wait_to(b + 73); press(0, 1, 0);   // RUN -> LAP
    wait_to(b + 77); at_max = 1'b1;
    wait_to(b + 79);
    check("sat_no_inc", inc0, 0);
    wait_to(b + 81); at_max = 1'b0;

    c = b + 90;
    q1.push_back(mk(c + 4,  0, 0, RUN,   0));
    q1.push_back(mk(c + 7,  1, 0, RUN,   0));
    q1.push_back(mk(c + 11, 1, 0, RUN,   0));
    q1.push_back(mk(c + 15, 1, 0, RUN,   0));
    q1.push_back(mk(c + 17, 0, 0, PAUSE, 0));
    wait_to(c);
    b1_start = 1'b1;
    @(negedge clock);
    b1_start = 1'b0;
    wait_to(c + 8);  at_max1 = 1'b1;
    wait_to(c + 11);
    check("wrap_inc_at_max", inc1, 1);
    wait_to(c + 12);
    check("wrap_state_run", st1, RUN);
    wait_to(c + 13);
    b1_start = 1'b1;
    @(negedge clock);
    b1_start = 1'b0;
    at_max1 = 1'b0;

    wait_to(c + 25);
    check("dut0_events_left", q0.size(), 0);
    check("dut1_events_left", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
